fixed_cast_skid_mmt: RTL and testbench
======================================

// Module: fixed_cast_skid_mmt
// PURPOSE
//  Vector fixed-point requantiser directly downstream of the leaky-ReLU stage.
//  Converts each IN_SIZE lane from (IN_WIDTH, IN_FRAC_WIDTH) to (OUT_WIDTH, OUT_FRAC_WIDTH):
//  shift, round half-up, saturate.
//  Registers the result behind a 2-entry skid buffer, so data_in_ready is a flop and
//  the combinational valid/ready path of the activation is cut.
//  Counts saturation events for debug.
// PARAMETERS
//  IN_WIDTH        8   signed input lane width
//  IN_FRAC_WIDTH   4   input fractional bits
//  OUT_WIDTH       4   signed output lane width
//  OUT_FRAC_WIDTH  2   output fractional bits
//  IN_SIZE         8   lanes per beat
//  CNT_WIDTH       16  saturation counter width
// PORTS
//  clk             in   1                    clock, all state on rising edge
//  rst             in   1                    synchronous, active-high reset
//  data_in         in   IN_WIDTH x IN_SIZE   input lanes (unpacked array)
//  data_in_valid   in   1                    input beat valid
//  data_in_ready   out  1                    input beat accepted when valid&ready
//  data_out        out  OUT_WIDTH x IN_SIZE  requantised lanes
//  data_out_valid  out  1                    output beat valid
//  data_out_ready  in   1                    downstream accepts when valid&ready
//  sat_count       out  CNT_WIDTH            lanes saturated since reset; sticks at all-ones
// BEHAVIOUR
//  Reset: data_out_valid=0, data_in_ready=1, sat_count=0, data_out=0, skid empty.
//  Cast (per lane, combinational, before the register):
//  - D = IN_FRAC_WIDTH - OUT_FRAC_WIDTH.
//  - D<=0: v = in <<< -D.
//  - D>0: v = (in + 2^(D-1)) >>> D, i.e. round half toward +inf.
//  - Intermediate is sign-extended to IN_WIDTH + |D| + 1 bits; the rounding add never overflows.
//  - Saturation: v > 2^(OUT_WIDTH-1)-1 -> max; v < -2^(OUT_WIDTH-1) -> min; else truncate.
//  - Saturation flag per lane = clamp applied.
//  States: EMPTY, ONE (output reg full), FULL (output reg + skid full).
//  - EMPTY: in_fire loads the output reg -> ONE. Latency 1 cycle, valid to data_out_valid.
//  - ONE, in_fire and out_fire: output reg reloads, stay ONE (full throughput).
//  - ONE, in_fire only: beat goes to skid -> FULL.
//  - ONE, out_fire only: -> EMPTY.
//  - FULL: data_in_ready=0. out_fire moves skid into the output reg -> ONE.
//  - data_in_ready = (state != FULL), registered; never depends on data_out_ready in the same cycle.
//  Ordering and stability:
//  - Beats leave in arrival order. No beat is dropped or duplicated.
//  - data_out is stable while data_out_valid=1 and data_out_ready=0.
//  - data_in_valid while data_in_ready=0 is ignored; the source must hold the beat.
//  sat_count:
//  - On each in_fire, adds the popcount of that beat's lane saturation flags.
//  - Clamps at 2^CNT_WIDTH-1 and never wraps, including when the add would cross the max.
//  Reset mid-operation: both buffer entries are discarded; outputs return to reset values the next cycle.
//  data_out lanes hold the last value when invalid; downstream must ignore them.
// TESTING
//  (defaults, IN_SIZE=2)
//  1. Lane 8'h16 (1.375) -> 4'h6 one cycle later.
//     Lane 8'hFE (-0.125 -> -0.5) -> 4'h0 (half-up).
//     sat_count stays 0.
//  2. Lanes 8'h7F, 8'h80 -> 4'h7, 4'h8.
//     sat_count=2. Repeat the beat -> 4.
//  3. Stream 10 beats with data_out_ready=1 -> 10 beats out in order, back-to-back.
//     data_in_ready stays 1.
//  4. Hold data_out_ready=0 and send 3 beats:
//     - beats 1-2 are accepted, then data_in_ready=0 while beat 3 is held;
//     - release ready -> 3 beats out in order, no loss or duplicate.
//  5. Preload sat_count to 2^16-2 via forced beats, then a beat with 2 saturated lanes ->
//     sat_count=16'hFFFF and stays there.
//  6. Assert rst with FULL state -> next cycle data_out_valid=0, data_in_ready=1, sat_count=0.
//     Later beats pass normally.

Source files
------------

// File: rtl/fixed_cast_skid_mmt.sv
// ============================================================================
// Module  : fixed_cast_skid_mmt
// Purpose : Vector fixed-point requantiser (shift, round half-up, saturate)
//           behind a 2-entry skid buffer, with a sticky saturation counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_cast_skid_mmt #(
  parameter int IN_WIDTH       = 8,
  parameter int IN_FRAC_WIDTH  = 4,
  parameter int OUT_WIDTH      = 4,
  parameter int OUT_FRAC_WIDTH = 2,
  parameter int IN_SIZE        = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [OUT_WIDTH-1:0] data_out [IN_SIZE],
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam int D  = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int AD = (D < 0) ? -D : D;
  localparam int EW = IN_WIDTH + AD + 1;
  // Compare width also covers outputs wider than the intermediate.
  localparam int CW = (EW > OUT_WIDTH + 1) ? EW : OUT_WIDTH + 1;
  localparam int PW = $clog2(IN_SIZE + 1);

  localparam logic signed [CW-1:0] MAXV = CW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [CW-1:0] MINV = ~MAXV;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [OUT_WIDTH-1:0] cast_beat [IN_SIZE];
  logic [IN_SIZE-1:0]   sat_flag;

  // Per-lane requantisation
  for (genvar i = 0; i < IN_SIZE; i++) begin : g_lane
    logic signed [CW-1:0] ext;
    logic signed [CW-1:0] v;

    assign ext = {{(CW - IN_WIDTH){data_in[i][IN_WIDTH-1]}}, data_in[i]};

    if (D > 0) begin : g_round
      localparam logic signed [CW-1:0] RND = CW'(2 ** (D - 1));
      assign v = (ext + RND) >>> D;
    end else begin : g_shl
      assign v = ext <<< AD;
    end

    assign sat_flag[i]  = (v > MAXV) || (v < MINV);
    assign cast_beat[i] = (v > MAXV) ? OUT_MAX :
                          (v < MINV) ? OUT_MIN : v[OUT_WIDTH-1:0];
  end

  logic [1:0]           state_q, state_d;
  logic [OUT_WIDTH-1:0] out_q  [IN_SIZE];
  logic [OUT_WIDTH-1:0] out_d  [IN_SIZE];
  logic [OUT_WIDTH-1:0] skid_q [IN_SIZE];
  logic [OUT_WIDTH-1:0] skid_d [IN_SIZE];
  logic                 in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  logic                 in_fire;
  logic                 out_fire;
  logic [PW-1:0]        sat_pop;
  logic [CNT_WIDTH:0]   sat_sum;

  assign in_fire  = data_in_valid && in_ready_q;
  assign out_fire = (state_q != S_EMPTY) && data_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      out_q       <= '{default: '0};
      skid_q      <= '{default: '0};
      in_ready_q  <= 1'b1;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      sat_count_q <= sat_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          out_d   = cast_beat;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          out_d = cast_beat;
        end else if (in_fire) begin
          skid_d  = cast_beat;
          state_d = S_FULL;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          out_d   = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Ready is registered from the next state so it never sees data_out_ready combinationally.
    in_ready_d = (state_d != S_FULL);

    sat_pop = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      sat_pop = sat_pop + PW'(sat_flag[i]);
    end
    sat_sum     = {1'b0, sat_count_q} + (CNT_WIDTH + 1)'(sat_pop);
    sat_count_d = sat_count_q;
    if (in_fire) begin
      sat_count_d = sat_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sat_sum[CNT_WIDTH-1:0];
    end
  end

  always_comb begin
    data_out_valid = (state_q != S_EMPTY);
    data_in_ready  = in_ready_q;
    data_out       = out_q;
    sat_count      = sat_count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_cast_skid_mmt.sv
// ============================================================================
// Module  : tb_fixed_cast_skid_mmt
// Purpose : Self-checking bench for fixed_cast_skid_mmt (IN_SIZE = 2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_cast_skid_mmt;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din [2];
  logic        din_valid;
  logic        din_ready;
  logic [3:0]  dout [2];
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] sat_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp_q [$];
  int         cnt_model = 0;

  always #5 clk = ~clk;

  fixed_cast_skid_mmt #(
    .IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(4), .OUT_FRAC_WIDTH(2),
    .IN_SIZE(2), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready),
    .data_out(dout), .data_out_valid(dout_valid), .data_out_ready(dout_ready),
    .sat_count(sat_count)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Real-valued reference: x/16 scaled to quarters, rounded half toward +inf, then clamped.
  function automatic void ref_cast(input logic [7:0] x, output logic [3:0] y, output int sat);
    int  xi;
    int  v;
    real r;
    xi = int'($signed(x));
    r  = real'(xi) / 16.0;
    v  = $rtoi($floor(r * 4.0 + 0.5));
    if (v > 7) begin
      y = 4'h7; sat = 1;
    end else if (v < -8) begin
      y = 4'h8; sat = 1;
    end else begin
      y = v[3:0]; sat = 0;
    end
  endfunction

  // Scoreboard: a 2-deep FIFO of expected beats plus a sticky saturation tally.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] y0, y1;
      int         s0, s1;
      chk_eq("out_valid", dout_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk_eq("data_out", {dout[1], dout[0]}, exp_q[0]);
      chk_eq("in_ready", din_ready, exp_q.size() < 2);
      chk_eq("sat_count", sat_count, cnt_model);
      if (rst) begin
        exp_q.delete();
        cnt_model = 0;
      end else begin
        if (dout_valid && dout_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (din_valid && din_ready) begin
          ref_cast(din[0], y0, s0);
          ref_cast(din[1], y1, s1);
          exp_q.push_back({y1, y0});
          cnt_model = cnt_model + s0 + s1;
          if (cnt_model > 65535) cnt_model = 65535;
        end
      end
    end
  end

  // Holds the current beat until accepted; returns just after the accepting edge.
  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!din_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
    din[0]    = a;
    din[1]    = b;
    din_valid = 1'b1;
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    din[0]     = '0;
    din[1]     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_eq("rst_valid", dout_valid, 1'b0);
    chk_eq("rst_ready", din_ready, 1'b1);
    chk_eq("rst_sat", sat_count, 16'd0);
    chk_eq("rst_dout", {dout[1], dout[0]}, 8'h00);
    mon_en = 1'b1;

    // Rounding: 1.375 -> 1.5, -0.125 -> 0 (half-up)
    send_beat(8'h16, 8'hFE);
    chk_eq("t1_valid", dout_valid, 1'b1);
    chk_eq("t1_dout", {dout[1], dout[0]}, 8'h06);
    chk_eq("t1_sat", sat_count, 16'd0);
    idle(2);

    // Saturation at both rails
    send_beat(8'h7F, 8'h80);
    chk_eq("t2_dout", {dout[1], dout[0]}, 8'h87);
    chk_eq("t2_sat", sat_count, 16'd2);
    send_beat(8'h7F, 8'h80);
    chk_eq("t2_sat_rep", sat_count, 16'd4);
    idle(2);

    // Back-to-back streaming at full throughput
    for (int i = 0; i < 10; i++) begin
      send_beat(8'($urandom), 8'($urandom));
      chk_eq("t3_ready", din_ready, 1'b1);
    end
    idle(3);

    // Backpressure: two beats fill the buffer, the third must be held
    dout_ready = 1'b0;
    send_beat(8'($urandom), 8'($urandom));
    send_beat(8'($urandom), 8'($urandom));
    din[0]    = 8'($urandom);
    din[1]    = 8'($urandom);
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_eq("t4_hold", din_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    wait_accept();
    idle(4);
    chk_eq("t4_drained", exp_q.size(), 0);

    // Drive the counter to its ceiling, then cross it
    while (cnt_model < 65534) begin
      if (cnt_model <= 65532) send_beat(8'h7F, 8'h80);
      else                    send_beat(8'h7F, 8'h00);
    end
    idle(1);
    chk_eq("t5_preload", sat_count, 16'hFFFE);
    send_beat(8'h80, 8'h7F);
    chk_eq("t5_cross", sat_count, 16'hFFFF);
    send_beat(8'h7F, 8'h7F);
    chk_eq("t5_stick", sat_count, 16'hFFFF);
    idle(3);

    // Reset while the buffer is full
    dout_ready = 1'b0;
    send_beat(8'($urandom), 8'($urandom));
    send_beat(8'($urandom), 8'($urandom));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_eq("t6_valid", dout_valid, 1'b0);
    chk_eq("t6_ready", din_ready, 1'b1);
    chk_eq("t6_sat", sat_count, 16'd0);
    chk_eq("t6_dout", {dout[1], dout[0]}, 8'h00);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'($urandom), 8'($urandom));
    idle(4);
    chk_eq("t6_drained", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
